half_to_flopoco_4_10: RTL



---
 rtl/flopoco_fmt_pkg.sv | 51 +++++
 rtl/half_to_flopoco_4_10_classify.sv | 40 ++++
 rtl/half_to_flopoco_4_10.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/flopoco_fmt_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : flopoco_fmt_pkg
//  Brief    : Shared definitions for the FloPoCo wE=4 / wF=10 float word and
//             the binary16 range classes used by the half-to-FloPoCo encoder.
//  Revision : 1.0 - initial release
// ============================================================================
package flopoco_fmt_pkg;

    localparam int WE        = 4;
    localparam int WF        = 10;
    localparam int FP_W      = 17;
    localparam int BIAS      = 7;
    localparam int HALF_BIAS = 15;

    // FloPoCo two-bit exception field
    localparam logic [1:0] EXC_ZERO   = 2'b00;
    localparam logic [1:0] EXC_NORMAL = 2'b01;
    localparam logic [1:0] EXC_INF    = 2'b10;
    localparam logic [1:0] EXC_NAN    = 2'b11;

    // Half exponent window that maps onto the wE=4 normal range (8..23)
    localparam logic [4:0] HALF_EXP_ALL1 = 5'd31;
    localparam logic [4:0] NORM_EXP_MIN  = 5'(HALF_BIAS - BIAS);
    localparam logic [4:0] NORM_EXP_MAX  = 5'(HALF_BIAS - BIAS + (1 << WE) - 1);

    typedef struct packed {
        logic [1:0]    exc;
        logic          sign;
        logic [WE-1:0] exp;
        logic [WF-1:0] frac;
    } flopoco_word_t;

    // Class of a binary16 input relative to the wE=4 target range
    typedef enum logic [2:0] {
        CLS_ZERO = 3'd0,   // exact zero
        CLS_SUB  = 3'd1,   // half subnormal, flushed
        CLS_UDF  = 3'd2,   // normal half below the target range
        CLS_NORM = 3'd3,   // representable normal
        CLS_OVF  = 3'd4,   // finite half above the target range
        CLS_INF  = 3'd5,   // infinity
        CLS_NAN  = 3'd6    // not-a-number
    } half_class_t;

    // Re-bias a representable half exponent (bias 15) to FloPoCo bias 7
    function automatic logic [WE-1:0] rebias(input logic [4:0] half_exp);
        return WE'(half_exp - NORM_EXP_MIN);
    endfunction

endpackage
`default_nettype wire

// File: rtl/half_to_flopoco_4_10_classify.sv
`default_nettype none
// ============================================================================
//  Module   : half_classify
//  Brief    : Combinational decode of an IEEE binary16 word into sign,
//             range class, raw exponent and fraction.
//  Revision : 1.0 - initial release
// ============================================================================
module half_classify
    import flopoco_fmt_pkg::*;
(
    input  logic [15:0]   i_half,
    output logic          o_sign,
    output half_class_t   o_cls,
    output logic [4:0]    o_exp,
    output logic [WF-1:0] o_frac
);

    logic          w_frac_nz;

    assign o_sign    = i_half[15];
    assign o_exp     = i_half[14:10];
    assign o_frac    = i_half[9:0];
    assign w_frac_nz = |i_half[9:0];

    // Range classification against the wE=4 normal window
    always_comb begin
        o_cls = CLS_NORM;
        if (o_exp == HALF_EXP_ALL1) begin
            o_cls = w_frac_nz ? CLS_NAN : CLS_INF;
        end else if (o_exp == 5'd0) begin
            o_cls = w_frac_nz ? CLS_SUB : CLS_ZERO;
        end else if (o_exp < NORM_EXP_MIN) begin
            o_cls = CLS_UDF;
        end else if (o_exp > NORM_EXP_MAX) begin
            o_cls = CLS_OVF;
        end
    end

endmodule
`default_nettype wire

// File: rtl/half_to_flopoco_4_10.sv
`default_nettype none
// ============================================================================
//  Module   : half_to_flopoco_4_10
//  Brief    : Two-stage valid/ready encoder from IEEE binary16 to the FloPoCo
//             17-bit float (wE=4, wF=10) with per-beat range flags and
//             saturating overflow/underflow event counters.
//             Build option HALF2FP_SATURATE_EN: overflow yields the largest
//             finite normal instead of infinity.
//  Revision : 1.0 - initial release
// ============================================================================
module half_to_flopoco_4_10
    import flopoco_fmt_pkg::*;
#(
    parameter int CNT_W                = 16,
    parameter bit FLUSH_SUBNORMAL_FLAG = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [FP_W-1:0]  out_data,
    output logic             out_ovf,
    output logic             out_udf,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] ovf_cnt,
    output logic [CNT_W-1:0] udf_cnt
);

    localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};

    // Decode of the incoming word
    logic          w_cls_sign;
    half_class_t   w_cls;
    logic [4:0]    w_cls_exp;
    logic [WF-1:0] w_cls_frac;

    // Stage 1 state
    logic          r_s1_valid;
    logic          r_s1_sign;
    half_class_t   r_s1_cls;
    logic [4:0]    r_s1_exp;
    logic [WF-1:0] r_s1_frac;

    // Stage 2 state
    logic            r_s2_valid;
    logic [FP_W-1:0] r_out_data;
    logic            r_out_ovf;
    logic            r_out_udf;

    logic [CNT_W-1:0] r_ovf_cnt;
    logic [CNT_W-1:0] r_udf_cnt;

    logic          w_s1_advance;
    logic          w_in_fire;
    logic          w_out_fire;
    flopoco_word_t w_pack;
    logic          w_pack_ovf;
    logic          w_pack_udf;

    half_classify u_classify (
        .i_half (in_data),
        .o_sign (w_cls_sign),
        .o_cls  (w_cls),
        .o_exp  (w_cls_exp),
        .o_frac (w_cls_frac)
    );

    assign w_s1_advance = !r_s2_valid || out_ready;
    assign in_ready     = !r_s1_valid || w_s1_advance;
    assign w_in_fire    = in_valid && in_ready;
    assign w_out_fire   = r_s2_valid && out_ready;

    assign out_valid = r_s2_valid;
    assign out_data  = r_out_data;
    assign out_ovf   = r_out_ovf;
    assign out_udf   = r_out_udf;
    assign ovf_cnt   = r_ovf_cnt;
    assign udf_cnt   = r_udf_cnt;

    // Stage 1: capture the decoded input whenever the slot can take a beat
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_sign  <= 1'b0;
            r_s1_cls   <= CLS_ZERO;
            r_s1_exp   <= 5'd0;
            r_s1_frac  <= '0;
        end else if (in_ready) begin
            r_s1_valid <= in_valid;
            if (w_in_fire) begin
                r_s1_sign <= w_cls_sign;
                r_s1_cls  <= w_cls;
                r_s1_exp  <= w_cls_exp;
                r_s1_frac <= w_cls_frac;
            end
        end
    end

    // Pack the stage-1 beat into a FloPoCo word and its range flags
    always_comb begin
        w_pack      = '0;
        w_pack.sign = r_s1_sign;
        w_pack_ovf  = 1'b0;
        w_pack_udf  = 1'b0;
        case (r_s1_cls)
            CLS_NAN:  w_pack.exc = EXC_NAN;
            CLS_INF:  w_pack.exc = EXC_INF;
            CLS_SUB:  w_pack_udf = FLUSH_SUBNORMAL_FLAG;
            CLS_UDF:  w_pack_udf = 1'b1;
            CLS_NORM: begin
                w_pack.exc  = EXC_NORMAL;
                w_pack.exp  = rebias(r_s1_exp);
                w_pack.frac = r_s1_frac;
            end
            CLS_OVF: begin
                w_pack_ovf = 1'b1;
`ifdef HALF2FP_SATURATE_EN
                w_pack.exc  = EXC_NORMAL;
                w_pack.exp  = '1;
                w_pack.frac = '1;
`else
                w_pack.exc  = EXC_INF;
`endif
            end
            default:  w_pack.exc = EXC_ZERO;
        endcase
    end

    // Stage 2: output register, held stable while downstream stalls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_valid <= 1'b0;
            r_out_data <= '0;
            r_out_ovf  <= 1'b0;
            r_out_udf  <= 1'b0;
        end else if (w_s1_advance) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_out_data <= w_pack;
                r_out_ovf  <= w_pack_ovf;
                r_out_udf  <= w_pack_udf;
            end
        end
    end

    // Saturating event counters; clear wins over a same-cycle increment
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf_cnt <= '0;
            r_udf_cnt <= '0;
        end else if (cnt_clr) begin
            r_ovf_cnt <= '0;
            r_udf_cnt <= '0;
        end else begin
            if (w_out_fire && r_out_ovf && (r_ovf_cnt != c_cnt_max)) begin
                r_ovf_cnt <= r_ovf_cnt + c_cnt_one;
            end
            if (w_out_fire && r_out_udf && (r_udf_cnt != c_cnt_max)) begin
                r_udf_cnt <= r_udf_cnt + c_cnt_one;
            end
        end
    end

endmodule
`default_nettype wire
